// File: rtl/trace_pkg.sv
// Shared definitions for the OR1K trace event path: opcode/register constants
// and the packed event layout {ts, id, value} used by the emitter and sink.
package trace_pkg;

  localparam logic [7:0] OR1K_OPC_NOP = 8'h15;
  localparam logic [4:0] R3_INDEX     = 5'd3;

  localparam int TS_WIDTH_DEF  = 32;
  localparam int ID_WIDTH_DEF  = 16;
  localparam int VALUE_WIDTH   = 32;
  localparam int DROP_WIDTH    = 16;

  // Default-width event as seen by the trace sink; field order is the
  // packing order used on the FIFO data path.
  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0] ts;
    logic [ID_WIDTH_DEF-1:0] id;
    logic [VALUE_WIDTH-1:0]  value;
  } trace_event_t;

  function automatic int event_width(input int ts_w, input int id_w);
    return ts_w + id_w + VALUE_WIDTH;
  endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// Small synchronous FIFO with registered storage. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; pops on empty are ignored.
module trace_event_fifo #(
  parameter  int WIDTH = 80,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy; depth is a power of two so the
  // pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/trace_event_emitter.sv
// OR1K trace source: shadows r3 from writeback, turns l.nop with a non-zero
// immediate into {ts, id, r3} events, and queues them toward the trace sink.
module trace_event_emitter
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic                  wb_we,
  input  logic [4:0]            wb_addr,
  input  logic [31:0]           wb_data,
  input  logic                  insn_valid,
  input  logic [31:0]           insn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TS_WIDTH-1:0]   out_ts,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [31:0]           out_value,
  output logic [DROP_WIDTH-1:0] drop_count,
  output logic                  overflow
);

  localparam int EV_W  = event_width(TS_WIDTH, ID_WIDTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]           r3_q, r3_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  ovf_q, ovf_d;

  logic                  wb_r3_hit;
  logic                  trigger;
  logic [31:0]           ev_value;
  logic [EV_W-1:0]       ev_data;
  logic [EV_W-1:0]       head_data;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  pop;
  logic                  drop;
  logic                  unused_insn;

  assign wb_r3_hit = wb_valid && wb_we && (wb_addr == R3_INDEX);
  assign trigger   = insn_valid && (insn[31:24] == OR1K_OPC_NOP) && (insn[15:0] != 16'h0);
  // A same-cycle r3 write must be visible to the event captured in that cycle.
  assign ev_value  = wb_r3_hit ? wb_data : r3_q;
  assign ev_data   = {ts_q, insn[ID_WIDTH-1:0], ev_value};
  assign unused_insn = ^insn[23:16];

  assign out_valid = (fifo_count != '0);
  assign pop       = out_ready && !fifo_empty;
  assign drop      = trigger && fifo_full && !pop;

  assign {out_ts, out_id, out_value} = head_data;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

  trace_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (trigger),
    .pop_i   (pop),
    .wdata_i (ev_data),
    .rdata_o (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state for r3 shadow, free-running timestamp and drop bookkeeping.
  always_comb begin
    r3_d   = r3_q;
    ts_d   = ts_q + TS_WIDTH'(1);
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (wb_r3_hit) r3_d = wb_data;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != {DROP_WIDTH{1'b1}}) drop_d = drop_q + DROP_WIDTH'(1);
    end
  end

  // State registers; overflow and drop count clear only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_q   <= '0;
      ts_q   <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      r3_q   <= r3_d;
      ts_q   <= ts_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule
